// File: rtl/adc_spi_responder.sv
// SPI responder emulating a dual-channel 10-bit SAR ADC: decodes a start/SGL/ODD/MSBF
// command and returns a null bit followed by the selected channel's sample.
module adc_spi_responder #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DATA_BITS   = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sclk,
  input  logic                 ncs,
  input  logic                 din,
  input  logic [DATA_BITS-1:0] ch0Sample,
  input  logic [DATA_BITS-1:0] ch1Sample,
  output logic                 dout,
  output logic                 chSel,
  output logic                 frameDone,
  output logic [7:0]           frameCount
);

  localparam int unsigned CNT_W = $clog2(DATA_BITS) + 1;
  localparam int unsigned FC_W  = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_CFG,
    S_NULLB,
    S_DATA,
    S_DONE
  } state_e;

  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] ncs_sync_q;
  logic [SYNC_STAGES-1:0] din_sync_q;
  logic                   sclk_prev_q;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic                   odd_q, odd_d;
  logic                   msbf_q, msbf_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   dout_q, dout_d;
  logic                   ch_sel_q, ch_sel_d;
  logic                   frame_done_q, frame_done_d;
  logic [FC_W-1:0]        frame_count_q, frame_count_d;

  logic s_sclk, s_ncs, s_din, sclk_rise, sclk_fall;

  // Input synchronizers; the oldest stage is the clk-domain view of each pin.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_sync_q <= '0;
      ncs_sync_q  <= '0;
      din_sync_q  <= '0;
      sclk_prev_q <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      ncs_sync_q  <= {ncs_sync_q[SYNC_STAGES-2:0], ncs};
      din_sync_q  <= {din_sync_q[SYNC_STAGES-2:0], din};
      sclk_prev_q <= s_sclk;
    end
  end

  assign s_sclk    = sclk_sync_q[SYNC_STAGES-1];
  assign s_ncs     = ncs_sync_q[SYNC_STAGES-1];
  assign s_din     = din_sync_q[SYNC_STAGES-1];
  assign sclk_rise = s_sclk & ~sclk_prev_q;
  assign sclk_fall = ~s_sclk & sclk_prev_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      bit_cnt_q     <= '0;
      odd_q         <= 1'b0;
      msbf_q        <= 1'b0;
      shift_q       <= '0;
      dout_q        <= 1'b0;
      ch_sel_q      <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      odd_q         <= odd_d;
      msbf_q        <= msbf_d;
      shift_q       <= shift_d;
      dout_q        <= dout_d;
      ch_sel_q      <= ch_sel_d;
      frame_done_q  <= frame_done_d;
      frame_count_q <= frame_count_d;
    end
  end

  // Frame sequencer; a deasserted chip select outranks any same-cycle sclk edge.
  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    odd_d         = odd_q;
    msbf_d        = msbf_q;
    shift_d       = shift_q;
    dout_d        = dout_q;
    ch_sel_d      = ch_sel_q;
    frame_done_d  = 1'b0;
    frame_count_d = frame_count_q;

    case (state_q)
      S_IDLE: begin
        dout_d = 1'b0;
        if (!s_ncs) state_d = S_START;
      end
      S_START: begin
        if (s_ncs) begin
          state_d = S_IDLE;
          dout_d  = 1'b0;
        end else if (sclk_rise && s_din) begin
          state_d   = S_CFG;
          bit_cnt_d = '0;
        end
      end
      S_CFG: begin
        if (s_ncs) begin
          state_d = S_IDLE;
          dout_d  = 1'b0;
        end else if (sclk_rise) begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == CNT_W'(1)) odd_d = s_din;
          if (bit_cnt_q == CNT_W'(2)) begin
            // Sample is frozen here for the whole frame.
            msbf_d   = s_din;
            shift_d  = odd_q ? ch1Sample : ch0Sample;
            ch_sel_d = odd_q;
            state_d  = S_NULLB;
          end
        end
      end
      S_NULLB: begin
        if (s_ncs) begin
          state_d = S_IDLE;
          dout_d  = 1'b0;
        end else if (sclk_fall) begin
          dout_d    = 1'b0;
          bit_cnt_d = '0;
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        if (s_ncs) begin
          state_d = S_IDLE;
          dout_d  = 1'b0;
        end else if (sclk_fall) begin
          dout_d    = msbf_q ? shift_q[DATA_BITS-1] : shift_q[0];
          shift_d   = msbf_q ? (shift_q << 1) : (shift_q >> 1);
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == CNT_W'(DATA_BITS - 1)) state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (s_ncs) begin
          frame_done_d  = 1'b1;
          frame_count_d = frame_count_q + FC_W'(1);
          dout_d        = 1'b0;
          state_d       = S_IDLE;
        end else if (sclk_fall) begin
          dout_d = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        dout_d  = 1'b0;
      end
    endcase
  end

  assign dout       = dout_q;
  assign chSel      = ch_sel_q;
  assign frameDone  = frame_done_q;
  assign frameCount = frame_count_q;

endmodule

// File: tb/tb_adc_spi_responder.sv
// Directed bench for adc_spi_responder: bit-banged SPI master sampling dout on sclk rises.
module tb_adc_spi_responder;

  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned DATA_BITS   = 10;
  localparam int          HALF        = 4;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 sclk;
  logic                 ncs;
  logic                 din;
  logic [DATA_BITS-1:0] ch0Sample;
  logic [DATA_BITS-1:0] ch1Sample;
  logic                 dout;
  logic                 chSel;
  logic                 frameDone;
  logic [7:0]           frameCount;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;

  adc_spi_responder #(
    .SYNC_STAGES(SYNC_STAGES),
    .DATA_BITS  (DATA_BITS)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .sclk      (sclk),
    .ncs       (ncs),
    .din       (din),
    .ch0Sample (ch0Sample),
    .ch1Sample (ch1Sample),
    .dout      (dout),
    .chSel     (chSel),
    .frameDone (frameDone),
    .frameCount(frameCount)
  );

  always #5 clk = ~clk;

  // Counts high cycles of frameDone, so a stretched pulse shows up as an extra count.
  always @(negedge clk) if (frameDone === 1'b1) done_cnt <= done_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One sclk period starting in the low phase; dout is sampled just before the rise.
  task automatic sclk_cycle(input logic d, output logic s);
    din = d;
    repeat (HALF) @(negedge clk);
    s = dout;
    sclk = 1'b1;
    repeat (HALF) @(negedge clk);
    sclk = 1'b0;
  endtask

  // cmd = {start, SGL, ODD, MSBF}; rx collects the bits seen after the command.
  task automatic do_frame(input int lead, input logic [3:0] cmd, input int ncyc,
                          input bit chg, input logic [DATA_BITS-1:0] new_ch0,
                          output logic [15:0] rx);
    logic s;
    ncs = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < lead; i++) sclk_cycle(1'b0, s);
    for (int i = 3; i >= 0; i--) sclk_cycle(cmd[i], s);
    if (chg) ch0Sample = new_ch0;
    rx = '0;
    for (int i = 0; i < ncyc; i++) begin
      sclk_cycle(1'b0, s);
      rx = {rx[14:0], s};
    end
  endtask

  task automatic end_frame();
    ncs = 1'b1;
    din = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    logic [15:0] rx;
    logic        s;
    logic        any_dout;
    int          d0;

    reset = 1'b1; sclk = 1'b0; ncs = 1'b1; din = 1'b0;
    ch0Sample = '0; ch1Sample = '0;
    repeat (3) @(negedge clk);
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_chsel", 32'(chSel), 32'd0);
    check("rst_done", 32'(frameDone), 32'd0);
    check("rst_count", 32'(frameCount), 32'd0);
    reset = 1'b0;

    // Deselected: sclk activity must not produce data or frames.
    any_dout = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      sclk_cycle(1'b1, s);
      any_dout |= s | dout;
    end
    repeat (8) @(negedge clk);
    check("idle_dout", 32'(any_dout), 32'd0);
    check("idle_done", 32'(done_cnt), 32'd0);
    check("idle_count", 32'(frameCount), 32'd0);

    // MSB-first channel 0: null, 10'h2A5, trailing zero.
    ch0Sample = 10'h2A5; ch1Sample = 10'h155;
    d0 = done_cnt;
    do_frame(0, 4'b1101, 12, 1'b0, '0, rx);
    end_frame();
    check("f1_rx", 32'(rx[11:0]), 32'h54A);
    check("f1_chsel", 32'(chSel), 32'd0);
    check("f1_done", 32'(done_cnt - d0), 32'd1);
    check("f1_count", 32'(frameCount), 32'd1);

    // Leading zeros, LSB-first channel 1 with 10'h003 -> received 1,1,0...0.
    ch1Sample = 10'h003;
    d0 = done_cnt;
    do_frame(2, 4'b1110, 12, 1'b0, '0, rx);
    end_frame();
    check("f2_rx", 32'(rx[11:0]), 32'h600);
    check("f2_chsel", 32'(chSel), 32'd1);
    check("f2_done", 32'(done_cnt - d0), 32'd1);
    check("f2_count", 32'(frameCount), 32'd2);

    // Channel input cleared after the latch point must not disturb the frame.
    ch0Sample = 10'h2A5;
    do_frame(0, 4'b1101, 12, 1'b1, 10'h000, rx);
    end_frame();
    check("latch_rx", 32'(rx[11:0]), 32'h54A);
    check("latch_chsel", 32'(chSel), 32'd0);
    check("latch_count", 32'(frameCount), 32'd3);

    // Abort after the 4th data bit with all-ones data so dout is high beforehand.
    ch0Sample = 10'h3FF;
    d0 = done_cnt;
    do_frame(0, 4'b1101, 4, 1'b0, '0, rx);
    repeat (HALF) @(negedge clk);
    check("abort_pre_dout", 32'(dout), 32'd1);
    ncs = 1'b1;
    repeat (SYNC_STAGES + 2) @(negedge clk);
    check("abort_dout", 32'(dout), 32'd0);
    repeat (8) @(negedge clk);
    check("abort_done", 32'(done_cnt - d0), 32'd0);
    check("abort_count", 32'(frameCount), 32'd3);
    ch0Sample = 10'h2A5;
    do_frame(0, 4'b1101, 12, 1'b0, '0, rx);
    end_frame();
    check("post_abort_rx", 32'(rx[11:0]), 32'h54A);
    check("post_abort_count", 32'(frameCount), 32'd4);

    // Counter wrap from a fresh reset.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    d0 = done_cnt;
    for (int i = 0; i < 255; i++) begin
      do_frame(0, 4'b1101, 12, 1'b0, '0, rx);
      end_frame();
    end
    check("wrap_255", 32'(frameCount), 32'd255);
    do_frame(0, 4'b1101, 12, 1'b0, '0, rx);
    end_frame();
    check("wrap_0", 32'(frameCount), 32'd0);
    check("wrap_done", 32'(done_cnt - d0), 32'd256);
    do_frame(0, 4'b1110, 12, 1'b0, '0, rx);
    end_frame();
    check("wrap_next", 32'(frameCount), 32'd1);

    // Async reset mid-DATA clears outputs without waiting for a clk edge.
    ch0Sample = 10'h3FF;
    do_frame(0, 4'b1101, 4, 1'b0, '0, rx);
    repeat (HALF) @(negedge clk);
    check("rst_mid_pre_dout", 32'(dout), 32'd1);
    #1 reset = 1'b1;
    #1;
    check("rst_mid_dout", 32'(dout), 32'd0);
    check("rst_mid_count", 32'(frameCount), 32'd0);
    check("rst_mid_chsel", 32'(chSel), 32'd0);
    ncs = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    ch0Sample = 10'h2A5;
    do_frame(0, 4'b1101, 12, 1'b0, '0, rx);
    end_frame();
    check("rst_post_rx", 32'(rx[11:0]), 32'h54A);
    check("rst_post_count", 32'(frameCount), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
